// File: rtl/processor_pkg.sv
// Shared types for the multicycle processor: instruction encodings, FSM states,
// ALU controls and flag bit positions.
package processor_pkg;

  typedef enum logic [2:0] {
    OpAlu     = 3'd0,
    OpAddi    = 3'd1,
    OpLoad    = 3'd2,
    OpStore   = 3'd3,
    OpB       = 3'd4,
    OpBeq     = 3'd5,
    OpHalt    = 3'd6,
    OpIllegal = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    FnAdd = 3'd0,
    FnSub = 3'd1,
    FnAnd = 3'd2,
    FnOr  = 3'd3
  } funct_e;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExecute,
    StMemory,
    StWriteback,
    StHalted
  } state_e;

  typedef enum logic [1:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr
  } alu_op_e;

  // Bit positions inside the {N,Z,C,V} flags vector.
  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

endpackage

// File: rtl/mc_control_fsm.sv
// Control FSM: sequences fetch/decode/execute/memory/writeback and emits
// en-qualified strobes that the datapath uses as register enables.
module mc_control_fsm
  import processor_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    en,
  input  logic    mem_ready,
  input  opcode_e opcode,
  input  logic    bad,
  output state_e  state,
  output logic    mem_req,
  output logic    mem_we,
  output logic    ir_load,
  output logic    op_load,
  output logic    ex_en,
  output logic    mem_done,
  output logic    wb_en,
  output logic    pc_seq,
  output logic    pc_branch,
  output logic    retire,
  output logic    illegal_set
);

  state_e state_q, state_d;
  // Keeps the bus idle for the first cycle after reset release.
  logic   run_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StFetch;
      run_q   <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    mem_req     = run_q && (state_q == StFetch || state_q == StMemory);
    mem_we      = (state_q == StMemory) && (opcode == OpStore);
    ir_load     = (state_q == StFetch) && mem_req && mem_ready && en;
    mem_done    = (state_q == StMemory) && mem_ready && en;
    op_load     = en && (state_q == StDecode);
    ex_en       = en && (state_q == StExecute);
    wb_en       = en && (state_q == StWriteback);
    illegal_set = op_load && bad;
    pc_branch   = ex_en && (opcode == OpB || opcode == OpBeq);
    pc_seq      = wb_en || (mem_done && opcode == OpStore);
    retire      = pc_seq || pc_branch;

    state_d = state_q;
    case (state_q)
      StFetch:     if (ir_load) state_d = StDecode;
      StDecode:    state_d = (bad || opcode == OpHalt) ? StHalted : StExecute;
      StExecute: begin
        case (opcode)
          OpLoad, OpStore: state_d = StMemory;
          OpB, OpBeq:      state_d = StFetch;
          default:         state_d = StWriteback;
        endcase
      end
      StMemory:    if (mem_done) state_d = (opcode == OpLoad) ? StWriteback : StFetch;
      StWriteback: state_d = StFetch;
      StHalted:    state_d = StHalted;
      default:     state_d = StFetch;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/multicycle_processor.sv
// Multicycle load/store core: register file, ALU, PC and bus datapath around
// the mc_control_fsm sequencer.
module multicycle_processor
  import processor_pkg::*;
#(
  parameter int unsigned  N        = 24,
  parameter int unsigned  REGS     = 16,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata,
  input  logic         mem_ready,
  output logic [N-1:0] pc_address,
  output logic [3:0]   flags,
  output logic         halted,
  output logic         illegal,
  output logic [31:0]  retired
);

  localparam int unsigned ImmW = N - 12;
  localparam int unsigned RegW = $clog2(REGS);

  logic [N-1:0] pc_q, ir_q, op_a_q, op_b_q, res_q;
  logic [N-1:0] regs_q [REGS];
  logic [3:0]   flags_q;
  logic         illegal_q;
  logic [31:0]  retired_q;

  state_e state;
  logic ir_load, op_load, ex_en, mem_done, wb_en, pc_seq, pc_branch, retire, illegal_set;

  opcode_e        opcode;
  funct_e         funct;
  logic [3:0]     rd, rs, rt;
  logic [ImmW-1:0] imm;
  logic           bad;

  assign opcode = opcode_e'(ir_q[N-1:N-3]);
  assign rd     = ir_q[N-5:N-8];
  assign rs     = ir_q[N-9:N-12];
  assign rt     = ir_q[N-13:N-16];
  assign funct  = funct_e'(ir_q[2:0]);
  assign imm    = ir_q[N-13:0];
  assign bad    = ir_q[N-4] || opcode == OpIllegal ||
                  (opcode == OpAlu && !(funct inside {FnAdd, FnSub, FnAnd, FnOr}));

  // Out-of-range register indices read as zero and never get written.
  logic [N-1:0] rs_val, rd_val, rt_val;
  assign rs_val = (32'(rs) < REGS) ? regs_q[rs[RegW-1:0]] : '0;
  assign rd_val = (32'(rd) < REGS) ? regs_q[rd[RegW-1:0]] : '0;
  assign rt_val = (32'(rt) < REGS) ? regs_q[rt[RegW-1:0]] : '0;

  logic [N-1:0] imm_z, br_off, pc_plus4, br_target;
  logic         taken;
  assign imm_z     = {{12{1'b0}}, imm};
  assign br_off    = {{12{imm[ImmW-1]}}, imm};
  assign pc_plus4  = pc_q + N'(4);
  assign br_target = pc_plus4 + {br_off[N-3:0], 2'b00};
  assign taken     = (opcode == OpB) || (opcode == OpBeq && op_a_q == op_b_q);

  alu_op_e      alu_op;
  logic [N-1:0] alu_b, alu_res;
  logic [N:0]   sum;
  logic [3:0]   alu_flags;

  always_comb begin
    alu_op = AluAdd;
    alu_b  = imm_z;
    if (opcode == OpAlu) begin
      alu_b = op_b_q;
      case (funct)
        FnSub:   alu_op = AluSub;
        FnAnd:   alu_op = AluAnd;
        FnOr:    alu_op = AluOr;
        default: alu_op = AluAdd;
      endcase
    end
    case (alu_op)
      AluSub:  sum = {1'b0, op_a_q} + {1'b0, ~alu_b} + {{N{1'b0}}, 1'b1};
      AluAnd:  sum = {1'b0, op_a_q & alu_b};
      AluOr:   sum = {1'b0, op_a_q | alu_b};
      default: sum = {1'b0, op_a_q} + {1'b0, alu_b};
    endcase
    alu_res          = sum[N-1:0];
    alu_flags        = '0;
    alu_flags[FlagN] = alu_res[N-1];
    alu_flags[FlagZ] = (alu_res == '0);
    // Logic ops never carry out of bit N-1, so sum[N] is already zero for them.
    alu_flags[FlagC] = sum[N];
    if (alu_op == AluAdd)
      alu_flags[FlagV] = (op_a_q[N-1] == alu_b[N-1]) && (alu_res[N-1] != op_a_q[N-1]);
    else if (alu_op == AluSub)
      alu_flags[FlagV] = (op_a_q[N-1] != alu_b[N-1]) && (alu_res[N-1] != op_a_q[N-1]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      res_q     <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
      for (int unsigned i = 0; i < REGS; i++) regs_q[i] <= '0;
    end else begin
      if (ir_load) ir_q <= mem_rdata;
      if (op_load) begin
        op_a_q <= rs_val;
        op_b_q <= (opcode == OpAlu) ? rt_val : rd_val;
      end
      if (illegal_set) illegal_q <= 1'b1;
      if (ex_en) begin
        res_q <= alu_res;
        if (opcode == OpAlu || opcode == OpAddi) flags_q <= alu_flags;
      end
      if (mem_done && opcode == OpLoad) res_q <= mem_rdata;
      if (wb_en && 32'(rd) < REGS) regs_q[rd[RegW-1:0]] <= res_q;
      if (pc_branch)   pc_q <= taken ? br_target : pc_plus4;
      else if (pc_seq) pc_q <= pc_plus4;
      if (retire) retired_q <= retired_q + 32'd1;
    end
  end

  mc_control_fsm u_fsm (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .mem_ready   (mem_ready),
    .opcode      (opcode),
    .bad         (bad),
    .state       (state),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .ir_load     (ir_load),
    .op_load     (op_load),
    .ex_en       (ex_en),
    .mem_done    (mem_done),
    .wb_en       (wb_en),
    .pc_seq      (pc_seq),
    .pc_branch   (pc_branch),
    .retire      (retire),
    .illegal_set (illegal_set)
  );

  assign mem_addr   = (state == StMemory) ? res_q : pc_q;
  assign mem_wdata  = op_b_q;
  assign pc_address = pc_q;
  assign flags      = flags_q;
  assign halted     = (state == StHalted);
  assign illegal    = illegal_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_processor.sv
// Directed bench for multicycle_processor: program ROM at 0x00-0x3C, data RAM
// at 0x40 and up with a configurable store-acknowledge delay.
module tb_multicycle_processor;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        mem_req, mem_we, mem_ready, halted, illegal;
  logic [23:0] mem_addr, mem_wdata, mem_rdata, pc_address;
  logic [3:0]  flags;
  logic [31:0] retired;

  int errors = 0;
  int checks = 0;

  logic [23:0] prog [16];
  logic [23:0] dmem [64];
  int store_wait = 0;
  int wcnt = 0;
  int store_writes = 0;
  int cycle = 0;
  logic [23:0] fetch_addr [$];
  int          fetch_cyc [$];

  always #5 clk = ~clk;

  multicycle_processor dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .pc_address (pc_address),
    .flags      (flags),
    .halted     (halted),
    .illegal    (illegal),
    .retired    (retired)
  );

  assign mem_rdata = (mem_addr[7:6] != 2'b00) ? dmem[mem_addr[7:2]] : prog[mem_addr[5:2]];
  assign mem_ready = mem_req && (!mem_we || wcnt >= store_wait);

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (en && mem_req && mem_we && mem_ready) begin
      dmem[mem_addr[7:2]] <= mem_wdata;
      store_writes <= store_writes + 1;
    end
    if (mem_req && mem_we && !mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always @(negedge clk) begin
    if (rst === 1'b1 && en && mem_req && mem_ready && !mem_we && mem_addr[7:6] == 2'b00) begin
      fetch_addr.push_back(mem_addr);
      fetch_cyc.push_back(cycle);
    end
  end

  function automatic logic [23:0] r_type(input logic [2:0] fn, input logic [3:0] rd,
                                         input logic [3:0] rs, input logic [3:0] rt);
    return {3'b000, 1'b0, rd, rs, rt, 5'b00000, fn};
  endfunction

  function automatic logic [23:0] i_type(input logic [2:0] op, input logic [3:0] rd,
                                         input logic [3:0] rs, input logic [11:0] imm);
    return {op, 1'b0, rd, rs, imm};
  endfunction

  localparam logic [23:0] Halt = {3'b110, 21'd0};

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = Halt;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_halted();
    for (int i = 0; i < 300 && halted !== 1'b1; i++) @(negedge clk);
  endtask

  task automatic wait_retired(input int k);
    for (int i = 0; i < 300 && retired !== 32'(k); i++) @(negedge clk);
  endtask

  task automatic test_reset();
    clear_prog();
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    checks++; if (pc_address !== 24'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", pc_address); end
    checks++; if (retired !== 32'd0) begin errors++; $display("FAIL rst_retired: got %0d want 0", retired); end
    checks++; if ({halted, illegal, flags} !== 6'd0) begin
      errors++; $display("FAIL rst_status: got %b want 000000", {halted, illegal, flags});
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_release_idle: got %b want 0", mem_req); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 24'h0) begin
      errors++; $display("FAIL rst_first_fetch: got req=%b addr=%h want req=1 addr=0", mem_req, mem_addr);
    end
  endtask

  task automatic test_alu();
    clear_prog();
    prog[0] = i_type(3'b001, 4'd1, 4'd0, 12'd5);
    prog[1] = i_type(3'b001, 4'd2, 4'd0, 12'd7);
    prog[2] = r_type(3'b000, 4'd3, 4'd1, 4'd2);
    prog[3] = i_type(3'b011, 4'd3, 4'd0, 12'h060);
    store_wait = 0;
    apply_reset();
    repeat (12) @(negedge clk);
    checks++; if (retired !== 32'd2) begin errors++; $display("FAIL alu_lat12: got %0d want 2", retired); end
    @(negedge clk);
    checks++; if (retired !== 32'd3) begin errors++; $display("FAIL alu_lat13: got %0d want 3", retired); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL alu_flags: got %b want 0000", flags); end
    wait_halted();
    checks++; if (dmem[24] !== 24'd12) begin errors++; $display("FAIL alu_r3: got %h want 00000c", dmem[24]); end
    checks++; if ({halted, illegal} !== 2'b10 || retired !== 32'd4) begin
      errors++; $display("FAIL alu_halt: got h=%b i=%b ret=%0d want h=1 i=0 ret=4", halted, illegal, retired);
    end
  endtask

  task automatic test_flags();
    logic [3:0] exp_flags [7];
    exp_flags = '{4'b0000, 4'b0110, 4'b0000, 4'b1000, 4'b0110, 4'b0000, 4'b1000};
    clear_prog();
    prog[0]  = i_type(3'b001, 4'd1, 4'd0, 12'd5);
    prog[1]  = r_type(3'b001, 4'd4, 4'd1, 4'd1);
    prog[2]  = i_type(3'b001, 4'd6, 4'd0, 12'd1);
    prog[3]  = r_type(3'b001, 4'd5, 4'd0, 4'd6);
    prog[4]  = r_type(3'b000, 4'd7, 4'd5, 4'd6);
    prog[5]  = r_type(3'b010, 4'd9, 4'd5, 4'd6);
    prog[6]  = r_type(3'b011, 4'd10, 4'd5, 4'd0);
    prog[7]  = i_type(3'b011, 4'd4, 4'd0, 12'h044);
    prog[8]  = i_type(3'b011, 4'd5, 4'd0, 12'h048);
    prog[9]  = i_type(3'b011, 4'd9, 4'd0, 12'h04C);
    prog[10] = i_type(3'b011, 4'd7, 4'd0, 12'h054);
    store_wait = 0;
    apply_reset();
    for (int k = 1; k <= 7; k++) begin
      wait_retired(k);
      checks++; if (flags !== exp_flags[k-1]) begin
        errors++; $display("FAIL flags_after_%0d: got %b want %b", k, flags, exp_flags[k-1]);
      end
    end
    wait_halted();
    checks++; if (dmem[17] !== 24'd0) begin errors++; $display("FAIL sub_r4: got %h want 0", dmem[17]); end
    checks++; if (dmem[18] !== 24'hFFFFFF) begin errors++; $display("FAIL sub_r5: got %h want ffffff", dmem[18]); end
    checks++; if (dmem[19] !== 24'd1) begin errors++; $display("FAIL and_r9: got %h want 1", dmem[19]); end
    checks++; if (dmem[21] !== 24'd0) begin errors++; $display("FAIL add_wrap_r7: got %h want 0", dmem[21]); end
    checks++; if (flags !== 4'b1000) begin errors++; $display("FAIL flags_store_keep: got %b want 1000", flags); end
  endtask

  task automatic test_store_load();
    int n = 0;
    int unstable = 0;
    int w0;
    clear_prog();
    prog[0] = i_type(3'b001, 4'd3, 4'd0, 12'd12);
    prog[1] = i_type(3'b011, 4'd3, 4'd0, 12'h040);
    prog[2] = i_type(3'b010, 4'd8, 4'd0, 12'h040);
    prog[3] = i_type(3'b011, 4'd8, 4'd0, 12'h050);
    store_wait = 3;
    apply_reset();
    w0 = store_writes;
    for (int i = 0; i < 50 && mem_we !== 1'b1; i++) @(negedge clk);
    while (mem_we === 1'b1 && n < 20) begin
      if (mem_req !== 1'b1 || mem_addr !== 24'h40 || mem_wdata !== 24'd12) unstable++;
      n++;
      @(negedge clk);
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL store_hold_cycles: got %0d want 4", n); end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL store_stable: got %0d bad cycles want 0", unstable); end
    checks++; if (store_writes - w0 !== 1) begin
      errors++; $display("FAIL store_once: got %0d writes want 1", store_writes - w0);
    end
    wait_halted();
    checks++; if (dmem[20] !== 24'd12) begin errors++; $display("FAIL load_back: got %h want 00000c", dmem[20]); end
    checks++; if (retired !== 32'd4) begin errors++; $display("FAIL ldst_retired: got %0d want 4", retired); end
    store_wait = 0;
  endtask

  task automatic test_enable();
    clear_prog();
    prog[0] = i_type(3'b001, 4'd1, 4'd0, 12'd3);
    apply_reset();
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 24'h0 || retired !== 32'd0) begin
      errors++; $display("FAIL en_freeze: got req=%b addr=%h ret=%0d want 1 0 0", mem_req, mem_addr, retired);
    end
    en = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (retired !== 32'd0) begin errors++; $display("FAIL en_resume3: got %0d want 0", retired); end
    @(negedge clk);
    checks++; if (retired !== 32'd1) begin errors++; $display("FAIL en_resume4: got %0d want 1", retired); end
    wait_halted();
  endtask

  task automatic test_branch();
    logic [23:0] exp_last [2];
    int base;
    exp_last = '{24'h00000C, 24'h000014};
    for (int c = 0; c < 2; c++) begin
      clear_prog();
      prog[0] = i_type(3'b001, 4'd1, 4'd0, 12'd5);
      prog[1] = i_type(3'b100, 4'd0, 4'd0, 12'd2);
      prog[4] = (c == 0) ? i_type(3'b101, 4'd1, 4'd1, 12'hFFE) : i_type(3'b101, 4'd1, 4'd2, 12'hFFE);
      base = fetch_addr.size();
      apply_reset();
      wait_halted();
      checks++; if (fetch_addr.size() - base !== 4) begin
        errors++; $display("FAIL br%0d_fetches: got %0d want 4", c, fetch_addr.size() - base);
      end else begin
        checks++; if (fetch_addr[base+2] !== 24'h10 || fetch_addr[base+3] !== exp_last[c]) begin
          errors++; $display("FAIL br%0d_target: got %h,%h want 000010,%h", c,
                             fetch_addr[base+2], fetch_addr[base+3], exp_last[c]);
        end
        checks++; if (fetch_cyc[base+1] - fetch_cyc[base] !== 4 ||
                      fetch_cyc[base+2] - fetch_cyc[base+1] !== 3 ||
                      fetch_cyc[base+3] - fetch_cyc[base+2] !== 3) begin
          errors++; $display("FAIL br%0d_latency: got %0d,%0d,%0d want 4,3,3", c,
                             fetch_cyc[base+1] - fetch_cyc[base], fetch_cyc[base+2] - fetch_cyc[base+1],
                             fetch_cyc[base+3] - fetch_cyc[base+2]);
        end
      end
      checks++; if (retired !== 32'd3 || illegal !== 1'b0) begin
        errors++; $display("FAIL br%0d_retired: got %0d ill=%b want 3 ill=0", c, retired, illegal);
      end
    end
  endtask

  task automatic test_illegal();
    logic [23:0] bad_ops [3];
    int req_seen;
    bad_ops = '{{3'b111, 21'd0}, r_type(3'b100, 4'd3, 4'd1, 4'd2), {3'b001, 1'b1, 20'h10005}};
    for (int v = 0; v < 3; v++) begin
      clear_prog();
      prog[0] = i_type(3'b001, 4'd1, 4'd0, 12'd1);
      prog[1] = i_type(3'b001, 4'd2, 4'd0, 12'd2);
      prog[2] = bad_ops[v];
      apply_reset();
      wait_halted();
      req_seen = 0;
      for (int i = 0; i < 5; i++) begin
        if (mem_req !== 1'b0) req_seen++;
        @(negedge clk);
      end
      checks++; if ({halted, illegal} !== 2'b11) begin
        errors++; $display("FAIL ill%0d_status: got h=%b i=%b want 1 1", v, halted, illegal);
      end
      checks++; if (retired !== 32'd2 || pc_address !== 24'h08) begin
        errors++; $display("FAIL ill%0d_state: got ret=%0d pc=%h want 2 000008", v, retired, pc_address);
      end
      checks++; if (req_seen !== 0) begin errors++; $display("FAIL ill%0d_req: got %0d want 0", v, req_seen); end
    end
  endtask

  task automatic test_reset_mid_store();
    int w0;
    clear_prog();
    prog[0] = i_type(3'b001, 4'd3, 4'd0, 12'd99);
    prog[1] = i_type(3'b011, 4'd3, 4'd0, 12'h040);
    store_wait = 1000;
    apply_reset();
    w0 = store_writes;
    for (int i = 0; i < 50 && mem_we !== 1'b1; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || retired !== 32'd1) begin
      errors++; $display("FAIL rs_pre: got req=%b we=%b ret=%0d want 1 1 1", mem_req, mem_we, retired);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL rs_drop: got req=%b we=%b want 0 0", mem_req, mem_we);
    end
    checks++; if (pc_address !== 24'h0 || retired !== 32'd0) begin
      errors++; $display("FAIL rs_state: got pc=%h ret=%0d want 0 0", pc_address, retired);
    end
    checks++; if (store_writes !== w0 || dmem[16] !== 24'd12) begin
      errors++; $display("FAIL rs_abandon: got writes=%0d mem=%h want %0d 00000c", store_writes, dmem[16], w0);
    end
    store_wait = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 24'h0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL rs_restart: got req=%b addr=%h want 1 000000", mem_req, mem_addr);
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    #2 rst = 1'b0;
    test_reset();
    test_alu();
    test_flags();
    test_store_load();
    test_enable();
    test_branch();
    test_illegal();
    test_reset_mid_store();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
